// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared types for the multiplier sequencing controller.
// Holds the FSM state encoding and the condition-flag bit indices.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

endpackage

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: operand magnitudes and product negation for signed multiply.
// Ports: i_signed, i_a, i_b -> o_mag_a, o_mag_b, o_neg; i_neg, i_prod -> o_result.
module mult_sign_fix (
    input  logic        i_signed,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic        i_neg,
    input  logic [15:0] i_prod,
    output logic [7:0]  o_mag_a,
    output logic [7:0]  o_mag_b,
    output logic        o_neg,
    output logic [15:0] o_result
);

    // 0x80 negates to 0x80, which the unsigned multiplier reads as 128.
    assign o_mag_a  = (i_signed && i_a[7]) ? (8'd0 - i_a) : i_a;
    assign o_mag_b  = (i_signed && i_b[7]) ? (8'd0 - i_b) : i_b;
    assign o_neg    = i_signed & (i_a[7] ^ i_b[7]);
    assign o_result = i_neg ? (16'd0 - i_prod) : i_prod;

endmodule

// File: rtl/mult_controller.sv
// mult_controller: drives the registered 8x8 multiplier and writes the
// 16-bit product back as two byte writes (low, then high) while stalling.
// Ports: i_clock, i_nreset; request i_req_*/o_req_ready; i_abort;
// multiplier o_mul_a/o_mul_b/o_mul_oe/i_mul_result; o_stall;
// write-back o_wb_en/o_wb_addr/o_wb_data; o_flags_we/o_flags_out {C,N,Z}.
// Option: MULT_CTRL_SIGNED_EN adds i_req_signed and signed multiplies.
module mult_controller
    import mult_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  i_clock,
    input  logic                  i_nreset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [7:0]            i_req_a,
    input  logic [7:0]            i_req_b,
    input  logic [REG_ADDR_W-1:0] i_req_rd,
`ifdef MULT_CTRL_SIGNED_EN
    input  logic                  i_req_signed,
`endif
    input  logic                  i_abort,
    output logic [7:0]            o_mul_a,
    output logic [7:0]            o_mul_b,
    output logic                  o_mul_oe,
    input  logic [15:0]           i_mul_result,
    output logic                  o_stall,
    output logic                  o_wb_en,
    output logic [REG_ADDR_W-1:0] o_wb_addr,
    output logic [7:0]            o_wb_data,
    output logic                  o_flags_we,
    output logic [2:0]            o_flags_out
);

    state_t r_state;
    state_t w_next;

    logic [7:0]            r_a;
    logic [7:0]            r_b;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [15:0]           r_result;

    logic                  w_accept;
    logic [7:0]            w_mag_a;
    logic [7:0]            w_mag_b;
    logic [15:0]           w_result;
    logic [REG_ADDR_W-1:0] w_rd_hi;

`ifdef MULT_CTRL_SIGNED_EN
    logic r_neg;
    logic w_neg;

    mult_sign_fix u_sign_fix (
        .i_signed (i_req_signed),
        .i_a      (i_req_a),
        .i_b      (i_req_b),
        .i_neg    (r_neg),
        .i_prod   (i_mul_result),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_neg    (w_neg),
        .o_result (w_result)
    );

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg;
        end
    end
`else
    assign w_mag_a  = i_req_a;
    assign w_mag_b  = i_req_b;
    assign w_result = i_mul_result;
`endif

    // abort in IDLE blocks acceptance for that cycle.
    assign o_req_ready = (r_state == S_IDLE) & ~i_abort;
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_rd_hi     = r_rd + {{(REG_ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_a  <= 8'd0;
            r_b  <= 8'd0;
            r_rd <= '0;
        end else if (w_accept) begin
            r_a  <= w_mag_a;
            r_b  <= w_mag_b;
            r_rd <= i_req_rd;
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_result <= 16'd0;
        end else if (r_state == S_READ) begin
            r_result <= w_result;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mul_a     = 8'd0;
        o_mul_b     = 8'd0;
        o_mul_oe    = 1'b0;
        o_wb_en     = 1'b0;
        o_wb_addr   = '0;
        o_wb_data   = 8'd0;
        o_flags_we  = 1'b0;
        o_flags_out = 3'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_mul_a = r_a;
                o_mul_b = r_b;
                w_next  = S_READ;
            end
            S_READ: begin
                o_mul_a  = r_a;
                o_mul_b  = r_b;
                o_mul_oe = 1'b1;
                w_next   = S_WB_LO;
            end
            S_WB_LO: begin
                o_wb_en   = 1'b1;
                o_wb_addr = r_rd;
                o_wb_data = r_result[7:0];
                w_next    = S_WB_HI;
            end
            S_WB_HI: begin
                o_wb_en             = 1'b1;
                o_wb_addr           = w_rd_hi;
                o_wb_data           = r_result[15:8];
                o_flags_we          = 1'b1;
                o_flags_out[FLAG_Z] = (r_result == 16'd0);
                o_flags_out[FLAG_N] = r_result[15];
                o_flags_out[FLAG_C] = 1'b0;
                w_next              = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (i_abort && r_state != S_IDLE) w_next = S_IDLE;
    end

    assign o_stall = (r_state != S_IDLE);

endmodule

// File: doc/mult_controller.md
# mult_controller

Sequencing controller for the ALU's registered 8x8 multiplier. Accepts one multiply request from the execute stage and drives the multiplier's operands and output enable on the shared ALU result bus. Captures the 16-bit product and writes it back as two byte writes (low then high) through the single 8-bit register-file write port. Holds the pipeline stalled for the duration of the operation.

## Interface
- REG_ADDR_W, 3, register-file address width; destination pair is rd and rd+1 modulo 2^REG_ADDR_W
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- req_valid  in  1  multiply request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_a  in  8  primary operand
- req_b  in  8  secondary operand
- req_rd  in  REG_ADDR_W  destination register for the low byte
- req_signed  in  1  signed multiply; present only with MULT_CTRL_SIGNED_EN
- abort  in  1  pipeline flush; cancels the in-flight operation
- mul_a  out  8  operand to multiplier primary input
- mul_b  out  8  operand to multiplier secondary input
- mul_oe  out  1  multiplier output enable onto the shared result bus
- mul_result  in  16  multiplier product, valid only while mul_oe=1
- stall  out  1  pipeline stall request
- wb_en  out  1  register-file write enable
- wb_addr  out  REG_ADDR_W  register-file write address
- wb_data  out  8  register-file write data
- flags_we  out  1  condition-flag write enable
- flags_out  out  3  {C, N, Z}

## Operation
- States: IDLE, LOAD, READ, WB_LO, WB_HI.
- IDLE: req_ready=1. On req_valid, latch the operands, rd and signedness, then go to LOAD.
- LOAD: mul_a and mul_b are driven from the latched operands. The multiplier registers the product at the end of this cycle. Go to READ.
- READ: mul_oe=1. Capture mul_result into the internal result_q (sign-corrected when signed). Go to WB_LO.
- WB_LO: wb_en=1, wb_addr=rd, wb_data=result_q[7:0]. Go to WB_HI.
- WB_HI: wb_en=1, wb_addr=rd+1 (wraps to 0 from 2^REG_ADDR_W-1), wb_data=result_q[15:8], flags_we=1. Go to IDLE.
- Flags are computed from the final result_q: Z = (result_q==0), N = result_q[15], C = 0.
- stall = (state != IDLE).
- mul_a and mul_b hold the latched operands from LOAD through READ. They are 0 in IDLE.
- mul_oe is 0 in every state except READ, so the shared bus is released.
- abort, sampled on a clock edge in any non-IDLE state, forces the next state to IDLE.
  - No further wb_en or flags_we pulses occur.
  - A low byte already written in WB_LO is not undone.
  - abort in IDLE has no effect, and it also blocks acceptance that cycle: req_ready=0 while abort=1.
- Asynchronous reset mid-operation returns to IDLE immediately. No write completes.

## Timing
- Accept edge = T0. LOAD in T0+1, READ in T0+2, WB_LO in T0+3, WB_HI in T0+4. req_ready is high again in T0+5.
- Throughput is one multiply per 5 cycles. There is no back-to-back acceptance.
- Reset values:
  - state=IDLE
  - req_ready=1 (after reset release)
  - mul_a=0, mul_b=0, mul_oe=0
  - stall=0
  - wb_en=0, wb_addr=0, wb_data=0
  - flags_we=0, flags_out=0
  - result_q=0
- All outputs are registered or decoded from state only. There is no combinational path from req_valid to any output except req_ready, which is gated by abort.

## Configuration
- MULT_CTRL_SIGNED_EN defined:
  - The req_signed port exists.
  - When req_signed=1, the controller sends operand magnitudes to the multiplier (0x80 is sent as 128).
  - It records sign = a[7]^b[7], and result_q = sign ? -mul_result : mul_result, in 16-bit two's complement.
- MULT_CTRL_SIGNED_EN undefined: the port is absent, all multiplies are unsigned, and the sign logic is not synthesized.

## Structure
- Package mult_ctrl_pkg holds:
  - the state enum and its 3-bit encoding (IDLE=0, LOAD=1, READ=2, WB_LO=3, WB_HI=4);
  - the flag bit indices (Z=0, N=1, C=2).
- One sub-module, mult_sign_fix: combinational operand magnitude and result negation. It is instantiated only under MULT_CTRL_SIGNED_EN.

## Test plan
- 0x0F*0x11 unsigned, rd=2 -> T0+3 writes r2=0xFF; T0+4 writes r3=0x00 with flags Z=0, N=0, C=0; stall high for exactly 4 cycles.
- 0xFF*0xFF, rd=7 -> r7=0x01, then r0=0xFE (address wrap); flags N=1, Z=0.
- 0x00*0x5A -> both bytes 0x00, Z=1; mul_oe high only in T0+2.
- abort asserted during READ -> no wb_en or flags_we pulses; req_ready=1 the next cycle. nreset pulsed low in WB_LO -> all outputs reset immediately; no WB_HI write.
- With MULT_CTRL_SIGNED_EN: 0xFE*0x03 signed -> 0xFFFA (r=0xFA, r+1=0xFF, N=1). 0x80*0x80 signed -> 0x4000. 0x80*0x7F signed -> 0xC080.
- req_valid held high continuously -> accepts occur only every 5 cycles; operands presented while busy are ignored.
